multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/arm_ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 26 ++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// instruction classes, opcode constants, ALU operation codes and the
// datapath strobe bundle.
package arm_ctrl_pkg;

  localparam int unsigned OPC_W   = 11;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ALUOP_W = 2;

  // FSM states; the numeric encoding is visible on the state port
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } cls_e;

  // Full 11-bit opcodes
  localparam logic [OPC_W-1:0] OPC_ADD  = 11'h458;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'h658;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'h450;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'h550;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'h7C2;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'h7C0;

  // Prefix-matched opcodes: CBZ on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0] OPC_CBZ_HI = 8'hB4;
  localparam logic [5:0] OPC_B_HI   = 6'h05;

  // ALU operation selects
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Datapath strobes and selects driven by the controller
  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               imem_read;
    logic               reg_to_loc;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               pc_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-class decoder for the multicycle controller.
module ctrl_decode
  import arm_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output cls_e             o_cls
);

  // Exact opcodes first, then the prefix-matched branch forms
  always_comb begin
    o_cls = CLS_ILLEGAL;
    if ((i_opcode == OPC_ADD) || (i_opcode == OPC_SUB) ||
        (i_opcode == OPC_AND) || (i_opcode == OPC_ORR)) begin
      o_cls = CLS_R;
    end else if (i_opcode == OPC_LDUR) begin
      o_cls = CLS_LDUR;
    end else if (i_opcode == OPC_STUR) begin
      o_cls = CLS_STUR;
    end else if (i_opcode[10:3] == OPC_CBZ_HI) begin
      o_cls = CLS_CBZ;
    end else if (i_opcode[10:5] == OPC_B_HI) begin
      o_cls = CLS_B;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for an ARM-subset datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB with memory handshakes, halts on request at an
// instruction boundary or on an illegal opcode, and keeps cycle and
// retired-instruction counters. Strobes are combinational from the state,
// the latched instruction class and the handshake inputs.
module multicycle_control
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                halt_req,
  output logic                pc_write,
  output logic                ir_write,
  output logic                imem_read,
  output logic                reg_to_loc,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                pc_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [STATE_W-1:0]  state,
  output logic                halted,
  output logic                illegal,
  output logic [PERF_W-1:0]   cycle_count,
  output logic [PERF_W-1:0]   instr_count
);

  state_e              r_state;
  cls_e                r_cls;
  logic                r_illegal;
  logic [PERF_W-1:0]   r_cycle;
  logic [PERF_W-1:0]   r_instr;

  state_e              w_next;
  cls_e                w_dec_cls;
  ctrl_t               w_ctrl;
  logic                w_retire;
  logic                w_set_illegal;

  ctrl_decode u_decode (
    .i_opcode (opcode),
    .o_cls    (w_dec_cls)
  );

  // Next state, retire pulse and datapath strobes for the current cycle
  always_comb begin
    w_ctrl        = '0;
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (halt_req) begin
          w_next = S_HALT;
        end else begin
          w_ctrl.imem_read = 1'b1;
          if (imem_ready) begin
            w_ctrl.ir_write = 1'b1;
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_src   = 1'b0;
            w_next          = S_DECODE;
          end
        end
      end

      // The class is only latched at the end of DECODE, so use the live decode
      S_DECODE: begin
        case (w_dec_cls)
          CLS_B: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_src   = 1'b1;
            w_retire        = 1'b1;
            w_next          = S_FETCH;
          end
          CLS_ILLEGAL: begin
            w_set_illegal = 1'b1;
            w_next        = S_HALT;
          end
          default: begin
            w_next = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        case (r_cls)
          CLS_R: begin
            w_ctrl.alu_op  = ALUOP_FUNCT;
            w_ctrl.alu_src = 1'b0;
            w_next         = S_WB;
          end
          CLS_LDUR, CLS_STUR: begin
            w_ctrl.alu_op  = ALUOP_ADD;
            w_ctrl.alu_src = 1'b1;
            w_next         = S_MEM;
          end
          CLS_CBZ: begin
            w_ctrl.alu_op     = ALUOP_PASS;
            w_ctrl.reg_to_loc = 1'b1;
            w_ctrl.pc_src     = 1'b1;
            w_ctrl.pc_write   = zero;
            w_retire          = 1'b1;
            w_next            = S_FETCH;
          end
          default: begin
            w_next = S_FETCH;
          end
        endcase
      end

      // Address stays on the ALU (add, immediate) for the whole access
      S_MEM: begin
        case (r_cls)
          CLS_LDUR: begin
            w_ctrl.alu_src  = 1'b1;
            w_ctrl.alu_op   = ALUOP_ADD;
            w_ctrl.mem_read = 1'b1;
            if (dmem_ready) begin
              w_next = S_WB;
            end
          end
          CLS_STUR: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.alu_op     = ALUOP_ADD;
            w_ctrl.mem_write  = 1'b1;
            w_ctrl.reg_to_loc = 1'b1;
            if (dmem_ready) begin
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
          end
          default: begin
            w_next = S_FETCH;
          end
        endcase
      end

      S_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = (r_cls == CLS_LDUR);
        w_retire          = 1'b1;
        w_next            = S_FETCH;
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Nothing may strobe the datapath while reset is held
    if (reset) begin
      w_ctrl = '0;
    end
  end

  // State, latched class, sticky illegal flag and performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cls     <= CLS_ILLEGAL;
      r_illegal <= 1'b0;
      r_cycle   <= '0;
      r_instr   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (r_state != S_HALT) begin
        r_cycle <= r_cycle + PERF_W'(1);
      end
      if (w_retire) begin
        r_instr <= r_instr + PERF_W'(1);
      end
    end
  end

  assign pc_write    = w_ctrl.pc_write;
  assign ir_write    = w_ctrl.ir_write;
  assign imem_read   = w_ctrl.imem_read;
  assign reg_to_loc  = w_ctrl.reg_to_loc;
  assign alu_src     = w_ctrl.alu_src;
  assign mem_read    = w_ctrl.mem_read;
  assign mem_write   = w_ctrl.mem_write;
  assign mem_to_reg  = w_ctrl.mem_to_reg;
  assign reg_write   = w_ctrl.reg_write;
  assign pc_src      = w_ctrl.pc_src;
  assign alu_op      = w_ctrl.alu_op;
  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign illegal     = r_illegal;
  assign cycle_count = r_cycle;
  assign instr_count = r_instr;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver walks each instruction
// through a cycle-level reference model, pushing the expected outputs for
// every cycle; a negedge monitor pops and compares them.
module tb_multicycle_control;

  localparam int unsigned PW = 8;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  // Strobe bit positions: {pc_write, ir_write, imem_read, reg_to_loc,
  // alu_src, mem_read, mem_write, mem_to_reg, reg_write, pc_src, alu_op}
  localparam logic [11:0] PCW   = 12'h800;
  localparam logic [11:0] IRW   = 12'h400;
  localparam logic [11:0] IMR   = 12'h200;
  localparam logic [11:0] RTL   = 12'h100;
  localparam logic [11:0] ASRC  = 12'h080;
  localparam logic [11:0] MRD   = 12'h040;
  localparam logic [11:0] MWR   = 12'h020;
  localparam logic [11:0] M2R   = 12'h010;
  localparam logic [11:0] RGW   = 12'h008;
  localparam logic [11:0] PCS   = 12'h004;
  localparam logic [11:0] ALU_F = 12'h002;
  localparam logic [11:0] ALU_P = 12'h001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   opcode = '0;
  logic          zero = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          halt_req = 1'b0;
  logic          pc_write, ir_write, imem_read, reg_to_loc, alu_src;
  logic          mem_read, mem_write, mem_to_reg, reg_write, pc_src;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic          halted, illegal;
  logic [PW-1:0] cycle_count, instr_count;
  logic [11:0]   act_sb;

  multicycle_control #(.PERF_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .halt_req    (halt_req),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .imem_read   (imem_read),
    .reg_to_loc  (reg_to_loc),
    .alu_src     (alu_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .pc_src      (pc_src),
    .alu_op      (alu_op),
    .state       (state),
    .halted      (halted),
    .illegal     (illegal),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign act_sb = {pc_write, ir_write, imem_read, reg_to_loc, alu_src,
                   mem_read, mem_write, mem_to_reg, reg_write, pc_src, alu_op};

  typedef struct {
    logic [2:0]    st;
    logic [11:0]   sb;
    logic          hlt;
    logic          ill;
    logic          chk;
    logic [PW-1:0] cyc;
    logic [PW-1:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state (driver side only)
  logic [PW-1:0] m_cyc = '0;
  logic [PW-1:0] m_ins = '0;
  logic          m_ill = 1'b0;
  logic          hreq = 1'b0;
  int            lc = 0;
  int            halt_idx = -1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: one expected record per clock cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("strobes", 32'(act_sb), 32'(e.sb));
      if (e.chk) begin
        check("state", 32'(state), 32'(e.st));
        check("halted", 32'(halted), 32'(e.hlt));
        check("illegal", 32'(illegal), 32'(e.ill));
        check("cycle_count", 32'(cycle_count), 32'(e.cyc));
        check("instr_count", 32'(instr_count), 32'(e.ins));
      end
    end
  end

  function automatic int classify(input logic [10:0] op);
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return C_R;
    if (op == 11'h7C2) return C_LD;
    if (op == 11'h7C0) return C_ST;
    if (op[10:3] == 8'hB4) return C_CBZ;
    if (op[10:5] == 6'h05) return C_B;
    return C_ILL;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus plus its expected outputs
  task automatic cyc(input logic [2:0] st, input logic [11:0] sb, input bit ret,
                     input logic imr, input logic dmr);
    exp_t e;
    if (halt_idx >= 0 && lc == halt_idx) hreq = 1'b1;
    reset      = 1'b0;
    halt_req   = hreq;
    imem_ready = imr;
    dmem_ready = dmr;
    e.st  = st;
    e.sb  = sb;
    e.hlt = (st == 3'd5);
    e.ill = m_ill;
    e.chk = 1'b1;
    e.cyc = m_cyc;
    e.ins = m_ins;
    exp_q.push_back(e);
    if (st != 3'd5) m_cyc = m_cyc + PW'(1);
    if (ret) m_ins = m_ins + PW'(1);
    lc++;
    @(posedge clk);
    #1;
  endtask

  // Reset cycle with every competing input asserted
  task automatic do_reset();
    exp_t e;
    reset      = 1'b1;
    halt_req   = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    e.st  = 3'd0;
    e.sb  = 12'h000;
    e.hlt = 1'b0;
    e.ill = 1'b0;
    e.chk = 1'b0;
    e.cyc = '0;
    e.ins = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    halt_req = 1'b0;
    m_cyc    = '0;
    m_ins    = '0;
    m_ill    = 1'b0;
    hreq     = 1'b0;
    halt_idx = -1;
  endtask

  task automatic halt_cycles(input int n);
    halt_idx = -1;
    for (int i = 0; i < n; i++) cyc(3'd5, 12'h000, 1'b0, rb(), rb());
  endtask

  // One instruction: iw imem waits, dw dmem waits, halt_req raised at local
  // cycle hidx, reset injected at MEM cycle rk; stopped=1 when the unit halts
  task automatic run(input logic [10:0] op, input logic z, input int iw, input int dw,
                     input int hidx, input int rk, output bit stopped);
    int c;
    stopped  = 1'b0;
    lc       = 0;
    halt_idx = hidx;
    opcode   = op;
    zero     = z;
    c        = classify(op);
    if (hreq) begin
      cyc(3'd0, 12'h000, 1'b0, rb(), rb());
      stopped = 1'b1;
      return;
    end
    for (int i = 0; i < iw; i++) cyc(3'd0, IMR, 1'b0, 1'b0, rb());
    cyc(3'd0, IMR | IRW | PCW, 1'b0, 1'b1, rb());
    if (c == C_B) begin
      cyc(3'd1, PCW | PCS, 1'b1, rb(), rb());
      return;
    end
    cyc(3'd1, 12'h000, 1'b0, rb(), rb());
    if (c == C_ILL) begin
      m_ill   = 1'b1;
      stopped = 1'b1;
      return;
    end
    if (c == C_R) begin
      cyc(3'd2, ALU_F, 1'b0, rb(), rb());
      cyc(3'd4, RGW, 1'b1, rb(), rb());
    end else if (c == C_CBZ) begin
      cyc(3'd2, (z ? PCW : 12'h000) | PCS | RTL | ALU_P, 1'b1, rb(), rb());
    end else begin
      cyc(3'd2, ASRC, 1'b0, rb(), rb());
      for (int k = 0; k <= dw; k++) begin
        if (k == rk) begin
          do_reset();
          return;
        end
        if (c == C_LD) cyc(3'd3, MRD | ASRC, 1'b0, rb(), 1'(k == dw));
        else           cyc(3'd3, MWR | RTL | ASRC, (k == dw), rb(), 1'(k == dw));
      end
      if (c == C_LD) cyc(3'd4, RGW | M2R, 1'b1, rb(), rb());
    end
  endtask

  function automatic logic [10:0] pick_op(input int cls);
    logic [10:0] rops [4];
    logic [10:0] op;
    rops[0] = 11'h458;
    rops[1] = 11'h658;
    rops[2] = 11'h450;
    rops[3] = 11'h550;
    case (cls)
      C_R:   op = rops[$urandom_range(0, 3)];
      C_LD:  op = 11'h7C2;
      C_ST:  op = 11'h7C0;
      C_CBZ: op = {8'hB4, 3'($urandom_range(0, 7))};
      C_B:   op = {6'h05, 5'($urandom_range(0, 31))};
      default: begin
        op = 11'($urandom);
        while (classify(op) != C_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    bit st;
    int k, cls, iw, dw, hidx, rk;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Directed scenarios
    run(11'h458, 1'b0, 0, 0, -1, -1, st);          // ADD
    run(11'h7C2, 1'b0, 0, 2, -1, -1, st);          // LDUR, dmem 2 waits
    run(11'h5A3, 1'b1, 0, 0, -1, -1, st);          // CBZ taken
    run(11'h5A0, 1'b0, 0, 0, -1, -1, st);          // CBZ not taken
    run(11'h0A7, 1'b0, 2, 0, -1, -1, st);          // B with imem waits
    run(11'h7C0, 1'b0, 1, 3, -1, 1, st);           // STUR, reset in MEM
    run(11'h7C0, 1'b0, 0, 1, -1, -1, st);          // STUR completes
    run(11'h658, 1'b0, 0, 0, 2, -1, st);           // SUB, halt_req in EXEC
    run(11'h458, 1'b0, 0, 0, -1, -1, st);          // halts at FETCH
    if (st) begin
      halt_cycles(3);
      do_reset();
    end
    run(11'h000, 1'b0, 0, 0, -1, -1, st);          // illegal
    if (st) begin
      halt_cycles(4);
      do_reset();
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      if (k <= 5 || k == 19) cls = C_R;
      else if (k <= 8)       cls = C_LD;
      else if (k <= 11)      cls = C_ST;
      else if (k <= 14)      cls = C_CBZ;
      else if (k <= 17)      cls = C_B;
      else                   cls = C_ILL;
      iw   = $urandom_range(0, 2);
      dw   = $urandom_range(0, 2);
      hidx = ($urandom_range(0, 19) == 0) ? iw + 1 : -1;
      rk   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, dw) : -1;
      run(pick_op(cls), rb(), iw, dw, hidx, rk, st);
      if (st) begin
        halt_cycles($urandom_range(1, 3));
        do_reset();
      end
    end

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
